// File: rtl/mips_multicycle_ctrl_pkg.sv
// rtl/mips_multicycle_ctrl_pkg.sv - encodings and per-state control decode for the multi-cycle sequencer
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_LW_WB    = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EXEC   = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_I_EXEC   = 4'd10,
      S_I_WB     = 4'd11,
      S_TRAP     = 4'd12
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SLL = 3'b011;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_ctl;
      logic [1:0] pc_source;
      logic       pc_write;
      logic       pc_write_cond;
      logic       illegal;
   } ctrl_t;

   // FETCH's pc_write is handshake-qualified in the top, so it is not set here.
   function automatic ctrl_t ctrl_decode(input state_e st, input logic [2:0] r_alu_ctl);
      ctrl_t c;
      c = '0;
      case (st)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = SRCB_FOUR;
            c.alu_ctl   = ALU_ADD;
         end
         S_DECODE: begin
            c.alu_src_b = SRCB_IMM_SL2;
            c.alu_ctl   = ALU_ADD;
         end
         S_MEM_ADDR, S_I_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.alu_ctl   = ALU_ADD;
         end
         S_MEM_RD: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
         end
         S_LW_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            c.mem_write = 1'b1;
            c.i_or_d    = 1'b1;
         end
         S_R_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_ctl   = r_alu_ctl;
         end
         S_R_WB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_ctl       = ALU_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = PCSRC_JUMP;
         end
         S_I_WB:  c.reg_write = 1'b1;
         S_TRAP:  c.illegal   = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - IR fields and datapath controls between sequencer and datapath
interface mips_multicycle_ctrl_if;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        mem_ready;
   logic        pc_en;
   logic        i_or_d;
   logic        mem_read;
   logic        mem_write;
   logic        ir_write;
   logic        reg_dst;
   logic        mem_to_reg;
   logic        reg_write;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [2:0]  alu_ctl;
   logic [1:0]  pc_source;
   logic        illegal;
   logic [3:0]  state;
   logic [31:0] retired;

   modport master (
      input  opcode, funct, zero, mem_ready,
      output pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
             reg_write, alu_src_a, alu_src_b, alu_ctl, pc_source, illegal, state, retired
   );

   modport slave (
      output opcode, funct, zero, mem_ready,
      input  pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
             reg_write, alu_src_a, alu_src_b, alu_ctl, pc_source, illegal, state, retired
   );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_ctl_decode.sv
// rtl/mips_multicycle_ctrl_alu_ctl_decode.sv - R-type funct to ALU operation map
module alu_ctl_decode
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] funct_i,
   output logic [2:0] alu_ctl_o,
   output logic       valid_o
);
   always_comb begin
      alu_ctl_o = ALU_ADD;
      valid_o   = 1'b1;
      case (funct_i)
         FN_ADD:  alu_ctl_o = ALU_ADD;
         FN_SUB:  alu_ctl_o = ALU_SUB;
         FN_AND:  alu_ctl_o = ALU_AND;
         FN_OR:   alu_ctl_o = ALU_OR;
         FN_SLT:  alu_ctl_o = ALU_SLT;
         FN_SLL:  alu_ctl_o = ALU_SLL;
         default: valid_o   = 1'b0;
      endcase
   end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS-subset control sequencer with retired-instruction count
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   mips_multicycle_ctrl_if.master  bus
);
   state_e      state_q, state_d;
   ctrl_t       ctrl_q;
   logic        run_q;
   logic [31:0] retired_q;
   logic [2:0]  r_alu_ctl;
   logic        funct_ok;
   logic        retire;
   logic        fetch_done;

   alu_ctl_decode u_alu_ctl_decode (
      .funct_i   (bus.funct),
      .alu_ctl_o (r_alu_ctl),
      .valid_o   (funct_ok)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.opcode)
               OP_RTYPE:       state_d = funct_ok ? S_R_EXEC : S_TRAP;
               OP_LW, OP_SW:   state_d = S_MEM_ADDR;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_J:           state_d = S_JUMP;
               OP_ADDI:        state_d = S_I_EXEC;
               default:        state_d = S_TRAP;
            endcase
         end
         S_MEM_ADDR: state_d = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   state_d = bus.mem_ready ? S_LW_WB : S_MEM_RD;
         S_MEM_WR:   state_d = bus.mem_ready ? S_FETCH : S_MEM_WR;
         S_R_EXEC:   state_d = S_R_WB;
         S_I_EXEC:   state_d = S_I_WB;
         default:    state_d = S_FETCH;
      endcase
   end

   // TRAP is the only return to FETCH that does not retire an instruction.
   assign retire = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_TRAP);

   // run_q holds the sequencer idle for the partial cycle after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q     <= 1'b0;
         state_q   <= S_FETCH;
         ctrl_q    <= '0;
         retired_q <= '0;
      end else if (!run_q) begin
         run_q  <= 1'b1;
         ctrl_q <= ctrl_decode(S_FETCH, r_alu_ctl);
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_decode(state_d, r_alu_ctl);
         if (retire) retired_q <= retired_q + 32'd1;
      end
   end

   assign fetch_done = run_q && (state_q == S_FETCH) && bus.mem_ready;

   assign bus.ir_write   = fetch_done;
   assign bus.pc_en      = fetch_done | ctrl_q.pc_write |
                           (ctrl_q.pc_write_cond & (bus.zero ^ (bus.opcode == OP_BNE)));
   assign bus.i_or_d     = ctrl_q.i_or_d;
   assign bus.mem_read   = ctrl_q.mem_read;
   assign bus.mem_write  = ctrl_q.mem_write;
   assign bus.reg_dst    = ctrl_q.reg_dst;
   assign bus.mem_to_reg = ctrl_q.mem_to_reg;
   assign bus.reg_write  = ctrl_q.reg_write;
   assign bus.alu_src_a  = ctrl_q.alu_src_a;
   assign bus.alu_src_b  = ctrl_q.alu_src_b;
   assign bus.alu_ctl    = ctrl_q.alu_ctl;
   assign bus.pc_source  = ctrl_q.pc_source;
   assign bus.illegal    = ctrl_q.illegal;
   assign bus.state      = state_q;
   assign bus.retired    = retired_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - randomized self-checking bench for the multi-cycle control sequencer
module tb_mips_multicycle_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   mips_multicycle_ctrl_if bus ();

   mips_multicycle_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_ret = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit r_known(input logic [5:0] fn);
      return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A || fn == 6'h00;
   endfunction

   function automatic logic [2:0] r_alu(input logic [5:0] fn);
      case (fn)
         6'h20:   return 3'b010;
         6'h22:   return 3'b110;
         6'h24:   return 3'b000;
         6'h25:   return 3'b001;
         6'h2A:   return 3'b111;
         default: return 3'b011;
      endcase
   endfunction

   // Expected per-cycle state trace built from the instruction class, then each cycle checked.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zr,
                            input int fw, input int mw);
      int seq[$];
      bit rdy[$];
      bit ill;
      int st;
      logic pc_exp;
      for (int i = 0; i < fw; i++) begin seq.push_back(0); rdy.push_back(1'b0); end
      seq.push_back(0); rdy.push_back(1'b1);
      seq.push_back(1); rdy.push_back(1'($urandom_range(0, 1)));
      ill = 1'b0;
      if (op == 6'h00 && r_known(fn)) begin
         seq.push_back(6); rdy.push_back(1'($urandom_range(0, 1)));
         seq.push_back(7); rdy.push_back(1'($urandom_range(0, 1)));
      end else if (op == 6'h23 || op == 6'h2B) begin
         seq.push_back(2); rdy.push_back(1'($urandom_range(0, 1)));
         for (int i = 0; i < mw; i++) begin seq.push_back(op == 6'h23 ? 3 : 5); rdy.push_back(1'b0); end
         seq.push_back(op == 6'h23 ? 3 : 5); rdy.push_back(1'b1);
         if (op == 6'h23) begin seq.push_back(4); rdy.push_back(1'($urandom_range(0, 1))); end
      end else if (op == 6'h04 || op == 6'h05) begin
         seq.push_back(8); rdy.push_back(1'($urandom_range(0, 1)));
      end else if (op == 6'h02) begin
         seq.push_back(9); rdy.push_back(1'($urandom_range(0, 1)));
      end else if (op == 6'h08) begin
         seq.push_back(10); rdy.push_back(1'($urandom_range(0, 1)));
         seq.push_back(11); rdy.push_back(1'($urandom_range(0, 1)));
      end else begin
         seq.push_back(12); rdy.push_back(1'($urandom_range(0, 1)));
         ill = 1'b1;
      end
      for (int i = 0; i < seq.size(); i++) begin
         @(negedge clk);
         bus.opcode    = op;
         bus.funct     = fn;
         bus.zero      = zr;
         bus.mem_ready = rdy[i];
         #1;
         st = seq[i];
         if (i == 0) chk("retired", bus.retired, exp_ret);
         chk("state", 32'(bus.state), 32'(st));
         chk("mem_read", 32'(bus.mem_read), 32'(st == 0 || st == 3));
         chk("mem_write", 32'(bus.mem_write), 32'(st == 5));
         chk("reg_write", 32'(bus.reg_write), 32'(st == 4 || st == 7 || st == 11));
         chk("illegal", 32'(bus.illegal), 32'(st == 12));
         chk("ir_write", 32'(bus.ir_write), 32'(st == 0 && rdy[i]));
         if (st == 0)      pc_exp = rdy[i];
         else if (st == 9) pc_exp = 1'b1;
         else if (st == 8) pc_exp = zr ^ (op == 6'h05);
         else              pc_exp = 1'b0;
         chk("pc_en", 32'(bus.pc_en), 32'(pc_exp));
         if (st == 3 || st == 5) chk("i_or_d", 32'(bus.i_or_d), 32'd1);
         if (st == 4) chk("mem_to_reg", 32'(bus.mem_to_reg), 32'd1);
         if (st == 4 || st == 11) chk("reg_dst_rt", 32'(bus.reg_dst), 32'd0);
         if (st == 7) chk("reg_dst_rd", 32'(bus.reg_dst), 32'd1);
         if (st == 6) chk("alu_ctl_r", 32'(bus.alu_ctl), 32'(r_alu(fn)));
         if (st == 8) chk("alu_ctl_br", 32'(bus.alu_ctl), 32'd6);
         if (st == 8) chk("pc_source_br", 32'(bus.pc_source), 32'd1);
         if (st == 9) chk("pc_source_j", 32'(bus.pc_source), 32'd2);
      end
      if (!ill) exp_ret = exp_ret + 32'd1;
   endtask

   logic [5:0] ops [8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h3F};
   logic [5:0] fns [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h3F};

   initial begin
      rst_n = 1'b0;
      bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
      #3;
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_retired", bus.retired, 32'd0);
      chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
      chk("rst_pc_en", 32'(bus.pc_en), 32'd0);
      chk("rst_ir_write", 32'(bus.ir_write), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_instr(6'h00, 6'h20, 1'b0, 0, 0);
      run_instr(6'h23, 6'h00, 1'b0, 0, 2);
      run_instr(6'h04, 6'h00, 1'b1, 0, 0);
      run_instr(6'h05, 6'h00, 1'b1, 0, 0);
      run_instr(6'h3F, 6'h00, 1'b0, 0, 0);
      run_instr(6'h00, 6'h3F, 1'b0, 0, 0);

      @(negedge clk);
      bus.mem_ready = 1'b0;
      force dut.retired_q = 32'hFFFF_FFFF;
      #1;
      release dut.retired_q;
      exp_ret = 32'hFFFF_FFFF;
      run_instr(6'h02, 6'h00, 1'b0, 0, 0);

      for (int k = 0; k < 60; k++) begin
         logic [5:0] op;
         logic [5:0] fn;
         op = ops[$urandom_range(0, 7)];
         fn = fns[$urandom_range(0, 6)];
         if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
         run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
      end

      // sw abandoned by reset while waiting in MEM_WR
      @(negedge clk); bus.opcode = 6'h2B; bus.mem_ready = 1'b1; #1;
      chk("sw_fetch", 32'(bus.state), 32'd0);
      @(negedge clk); #1;
      chk("sw_decode", 32'(bus.state), 32'd1);
      @(negedge clk); #1;
      chk("sw_addr", 32'(bus.state), 32'd2);
      @(negedge clk); bus.mem_ready = 1'b0; #1;
      chk("sw_wr_state", 32'(bus.state), 32'd5);
      chk("sw_wr_strobe", 32'(bus.mem_write), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_mem_write", 32'(bus.mem_write), 32'd0);
      chk("mid_rst_state", 32'(bus.state), 32'd0);
      chk("mid_rst_retired", bus.retired, 32'd0);
      chk("mid_rst_mem_read", 32'(bus.mem_read), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_ret = '0;
      run_instr(6'h00, 6'h20, 1'b0, 0, 0);
      run_instr(6'h2B, 6'h00, 1'b0, 1, 1);

      @(negedge clk); bus.mem_ready = 1'b0; #1;
      chk("final_retired", bus.retired, exp_ret);
      chk("final_state", 32'(bus.state), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
